// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Package : sram_pkg
// Brief   : Shared types and constants for the SRAM arbiter slice.
// Rev     : 1.0
// ============================================================================
package sram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam int SRAM_ADDR_W = 18;
   localparam int WAIT_MAX    = 7;
   localparam int CNT_W       = $clog2(WAIT_MAX + 1);

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic dout_oe;
   } strobe_t;

   localparam strobe_t    c_strobe_idle = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dout_oe: 1'b0};
   localparam logic [3:0] c_be_idle_n   = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : sram_arbiter_if
// Brief     : Pipeline-side fetch and load/store request bundle.
// Rev       : 1.0
// ============================================================================
interface sram_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_ready;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_be;
   logic [31:0] data_rdata;
   logic        data_ready;

   modport master (
      output inst_req, inst_addr, data_read, data_write, data_addr, data_wdata, data_be,
      input  inst_rdata, inst_ready, data_rdata, data_ready
   );

   modport slave (
      input  inst_req, inst_addr, data_read, data_write, data_addr, data_wdata, data_be,
      output inst_rdata, inst_ready, data_rdata, data_ready
   );
endinterface
`default_nettype wire

// File: rtl/sram_io_reg.sv
`default_nettype none
// ============================================================================
// Module : sram_io_reg
// Brief  : Pad-side output registers for the SRAM pins, async active-low reset.
// Rev    : 1.0
// ============================================================================
module sram_io_reg
   import sram_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  strobe_t           strobe_d,
   input  logic              be_ld,
   input  logic [3:0]        be_n_d,
   input  logic              bus_ld,
   input  logic [ADDR_W-1:0] addr_d,
   input  logic [31:0]       dout_d,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_dout,
   output logic              sram_dout_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
);

   strobe_t           r_strobe;
   logic [3:0]        r_be_n;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_dout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_strobe <= c_strobe_idle;
         r_be_n   <= c_be_idle_n;
         r_addr   <= '0;
         r_dout   <= '0;
      end else begin
         r_strobe <= strobe_d;
         if (be_ld) begin
            r_be_n <= be_n_d;
         end
         if (bus_ld) begin
            r_addr <= addr_d;
            r_dout <= dout_d;
         end
      end
   end

   assign sram_addr    = r_addr;
   assign sram_dout    = r_dout;
   assign sram_dout_oe = r_strobe.dout_oe;
   assign sram_ce_n    = r_strobe.ce_n;
   assign sram_oe_n    = r_strobe.oe_n;
   assign sram_we_n    = r_strobe.we_n;
   assign sram_be_n    = r_be_n;

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sram_arbiter
// Brief  : Data-priority fetch/load/store arbiter and timing sequencer for the
//          shared asynchronous 32-bit SRAM.
// Rev    : 1.0
// ============================================================================
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ADDR_W      = SRAM_ADDR_W,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   sram_arbiter_if.slave     cpu,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_dout,
   output logic              sram_dout_oe,
   input  logic [31:0]       sram_din,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
);

   localparam logic [CNT_W-1:0] c_wait = CNT_W'(WAIT_CYCLES);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fetch;
   logic [31:0]      r_inst_rdata;
   logic [31:0]      r_data_rdata;
   logic             r_inst_ready;
   logic             r_data_ready;
   logic             w_grant;
   logic             w_data_sel;
   logic [31:0]      w_addr_sel;
   strobe_t          w_strobe;
   logic             w_be_ld;
   logic [3:0]       w_be_n_d;
   logic             w_unused;

   assign w_data_sel = cpu.data_read | cpu.data_write;
   assign w_addr_sel = w_data_sel ? cpu.data_addr : cpu.inst_addr;
   assign w_unused   = ^{w_addr_sel[31:ADDR_W+2], w_addr_sel[1:0]};

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cpu.data_write) begin
               w_state_nxt = ST_WR_SETUP;
               w_grant     = 1'b1;
            end else if (cpu.data_read || cpu.inst_req) begin
               w_state_nxt = ST_RD;
               w_grant     = 1'b1;
            end
         end
         ST_RD, ST_WR_PULSE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_WR_SETUP: w_state_nxt = ST_WR_PULSE;
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   // Pins are decoded from the next state so they change on the same edge as the FSM.
   always_comb begin
      w_strobe = c_strobe_idle;
      w_be_ld  = 1'b1;
      w_be_n_d = c_be_idle_n;
      case (w_state_nxt)
         ST_RD: begin
            w_strobe = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, dout_oe: 1'b0};
            w_be_n_d = 4'b0000;
         end
         ST_WR_SETUP: begin
            w_strobe = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, dout_oe: 1'b1};
            w_be_n_d = ~cpu.data_be;
         end
         ST_WR_PULSE: begin
            w_strobe = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, dout_oe: 1'b1};
            w_be_ld  = 1'b0;
         end
         ST_DONE: begin
            w_strobe = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dout_oe: (r_state == ST_WR_PULSE)};
            w_be_ld  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_fetch      <= 1'b0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
         r_inst_ready <= 1'b0;
         r_data_ready <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_inst_ready <= 1'b0;
         r_data_ready <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_cnt   <= c_wait;
                  r_fetch <= ~w_data_sel;
               end
            end
            ST_WR_SETUP: r_cnt <= c_wait;
            ST_RD: begin
               if (r_cnt == '0) begin
                  if (r_fetch) begin
                     r_inst_rdata <= sram_din;
                     r_inst_ready <= 1'b1;
                  end else begin
                     r_data_rdata <= sram_din;
                     r_data_ready <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_WR_PULSE: begin
               if (r_cnt == '0) begin
                  r_data_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign cpu.inst_rdata = r_inst_rdata;
   assign cpu.inst_ready = r_inst_ready;
   assign cpu.data_rdata = r_data_rdata;
   assign cpu.data_ready = r_data_ready;

   sram_io_reg #(
      .ADDR_W (ADDR_W)
   ) u_io_reg (
      .clk          (clk),
      .rst          (rst),
      .strobe_d     (w_strobe),
      .be_ld        (w_be_ld),
      .be_n_d       (w_be_n_d),
      .bus_ld       (w_grant),
      .addr_d       (w_addr_sel[ADDR_W+1:2]),
      .dout_d       (cpu.data_wdata),
      .sram_addr    (sram_addr),
      .sram_dout    (sram_dout),
      .sram_dout_oe (sram_dout_oe),
      .sram_ce_n    (sram_ce_n),
      .sram_oe_n    (sram_oe_n),
      .sram_we_n    (sram_we_n),
      .sram_be_n    (sram_be_n)
   );

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_arbiter
// Brief  : Self-checking bench: pin-level SRAM device plus word-level reference memory.
// Rev    : 1.0
// ============================================================================
module tb_sram_arbiter;
   import sram_pkg::*;

   localparam int WAIT   = 1;
   localparam int AW     = 18;
   localparam int RD_LAT = WAIT + 2;
   localparam int WR_LAT = WAIT + 3;
   localparam int RD_PER = WAIT + 3;
   localparam int K_FETCH = 0, K_LOAD = 1, K_STORE = 2, K_BOTH = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sram_arbiter_if cpu ();
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_dout, sram_din;
   logic          sram_dout_oe, sram_ce_n, sram_oe_n, sram_we_n;
   logic [3:0]    sram_be_n;

   sram_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst(rst), .cpu(cpu),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_oe(sram_dout_oe),
      .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [31:0] ref_mem [0:255];
   logic [31:0] dev_mem [0:255];
   logic [31:0] exp_inst = '0;
   logic [31:0] exp_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Asynchronous SRAM device: reads while ce_n/oe_n low, writes enabled lanes while we_n low.
   bit dev_loaded = 1'b0;
   always @(posedge clk) begin
      if (!dev_loaded) begin
         for (int i = 0; i < 256; i++) dev_mem[i] = ref_mem[i];
         dev_loaded = 1'b1;
      end else if (!sram_ce_n && !sram_we_n) begin
         for (int l = 0; l < 4; l++)
            if (!sram_be_n[l])
               dev_mem[sram_addr[7:0]][8*l +: 8] = sram_dout_oe ? sram_dout[8*l +: 8] : 8'hFF;
      end
   end
   assign sram_din = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_addr[7:0]]
                                                : (32'hBAD0_0000 ^ 32'(sram_addr));

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = wd[8*l +: 8];
      return r;
   endfunction

   // Issues one access from a negedge while the arbiter is idle and measures the pin activity.
   task automatic run_access(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, output int lat, output int oe_low,
                             output int we_low, output int setup_n, output logic [3:0] be_seen,
                             output logic [AW-1:0] addr_seen, output int ip, output int dp,
                             output logic tmo);
      int  grant;
      bit  done;
      lat = 0; oe_low = 0; we_low = 0; setup_n = 0; be_seen = 4'hx; addr_seen = 'x;
      ip = 0; dp = 0; tmo = 1'b1; done = 1'b0;
      cpu.inst_req   = (kind == K_FETCH);
      cpu.data_read  = (kind == K_LOAD || kind == K_BOTH);
      cpu.data_write = (kind == K_STORE || kind == K_BOTH);
      if (kind == K_FETCH) cpu.inst_addr = addr; else cpu.data_addr = addr;
      cpu.data_wdata = wd;
      cpu.data_be    = be;
      grant = cyc + 1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (i == 0) begin
            cpu.inst_addr = $urandom; cpu.data_addr = $urandom;
            cpu.data_wdata = $urandom; cpu.data_be = 4'($urandom);
         end
         if (!sram_ce_n && sram_oe_n && sram_we_n) setup_n++;
         if (!sram_oe_n) oe_low++;
         if (!sram_we_n) begin we_low++; be_seen = sram_be_n; end
         if (!sram_ce_n) addr_seen = sram_addr;
         if (cpu.inst_ready) ip++;
         if (cpu.data_ready) dp++;
         if ((kind == K_FETCH && cpu.inst_ready) || (kind != K_FETCH && cpu.data_ready)) begin
            lat = cyc + 1 - grant;
            done = 1'b1;
            tmo = 1'b0;
         end
      end
      cpu.inst_req = 1'b0; cpu.data_read = 1'b0; cpu.data_write = 1'b0;
      @(negedge clk);
      if (cpu.inst_ready) ip++;
      if (cpu.data_ready) dp++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_oe} !== 4'b1110) begin n_fail++;
         $display("FAIL reset_strobes: got %b expected 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_oe}); end
      n_tests++; if (sram_be_n !== 4'b1111) begin n_fail++;
         $display("FAIL reset_be_n: got %b expected 1111", sram_be_n); end
      n_tests++; if (sram_addr !== '0 || sram_dout !== '0) begin n_fail++;
         $display("FAIL reset_bus: got addr %h dout %h expected 0", sram_addr, sram_dout); end
      n_tests++; if ({cpu.inst_rdata, cpu.data_rdata, cpu.inst_ready, cpu.data_ready} !== '0) begin n_fail++;
         $display("FAIL reset_cpu: got %h %h %b %b expected zeros", cpu.inst_rdata, cpu.data_rdata, cpu.inst_ready, cpu.data_ready); end
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111 || cpu.inst_ready !== 1'b0) begin n_fail++;
         $display("FAIL idle_after_reset: got %b %b expected 111 0", {sram_ce_n, sram_oe_n, sram_we_n}, cpu.inst_ready); end
   endtask

   task automatic test_fetch();
      int lat, oe, we, su, ip, dp; logic [3:0] bs; logic [AW-1:0] as; logic tmo;
      run_access(K_FETCH, 32'h0000_0010, 32'h0, 4'h0, lat, oe, we, su, bs, as, ip, dp, tmo);
      exp_inst = 32'hDEAD_BEEF;
      n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL fetch_timeout: got %b expected 0", tmo); end
      n_tests++; if (as !== AW'(4)) begin n_fail++; $display("FAIL fetch_addr: got %h expected 4", as); end
      n_tests++; if (oe != WAIT + 1) begin n_fail++; $display("FAIL fetch_oe_low: got %0d expected %0d", oe, WAIT + 1); end
      n_tests++; if (lat != RD_LAT) begin n_fail++; $display("FAIL fetch_latency: got %0d expected %0d", lat, RD_LAT); end
      n_tests++; if (cpu.inst_rdata !== exp_inst) begin n_fail++;
         $display("FAIL fetch_rdata: got %h expected %h", cpu.inst_rdata, exp_inst); end
      n_tests++; if (ip != 1 || dp != 0) begin n_fail++; $display("FAIL fetch_pulses: got %0d/%0d expected 1/0", ip, dp); end
   endtask

   task automatic test_store(input int kind);
      int lat, oe, we, su, ip, dp; logic [3:0] bs; logic [AW-1:0] as; logic tmo;
      logic [31:0] wd; logic [3:0] be;
      wd = 32'h1234_5678; be = 4'b0011;
      run_access(kind, 32'h0000_0104, wd, be, lat, oe, we, su, bs, as, ip, dp, tmo);
      ref_mem[8'h41] = merge(ref_mem[8'h41], wd, be);
      n_tests++; if (tmo !== 1'b0 || lat != WR_LAT) begin n_fail++;
         $display("FAIL store_latency: got %0d (tmo %b) expected %0d", lat, tmo, WR_LAT); end
      n_tests++; if (su != 1 || we != WAIT + 1 || oe != 0) begin n_fail++;
         $display("FAIL store_phases: got setup %0d we_low %0d oe_low %0d expected 1 %0d 0", su, we, oe, WAIT + 1); end
      n_tests++; if (bs !== 4'b1100) begin n_fail++; $display("FAIL store_be_n: got %b expected 1100", bs); end
      n_tests++; if (dev_mem[8'h41] !== ref_mem[8'h41]) begin n_fail++;
         $display("FAIL store_memory: got %h expected %h", dev_mem[8'h41], ref_mem[8'h41]); end
      n_tests++; if (cpu.data_rdata !== exp_data || ip != 0 || dp != 1) begin n_fail++;
         $display("FAIL store_no_capture: got rdata %h pulses %0d/%0d expected %h 0/1", cpu.data_rdata, ip, dp, exp_data); end
   endtask

   task automatic test_random();
      int lat, oe, we, su, ip, dp, k, idx; logic [3:0] bs; logic [AW-1:0] as; logic tmo;
      logic [31:0] a, wd, exp_w; logic [3:0] be;
      for (int n = 0; n < 24; n++) begin
         k = $urandom_range(0, 2);
         idx = $urandom_range(0, 31);
         a = {22'h0, idx[7:0], 2'($urandom)};
         wd = $urandom; be = 4'($urandom);
         run_access(k, a, wd, be, lat, oe, we, su, bs, as, ip, dp, tmo);
         if (k == K_STORE) ref_mem[idx] = merge(ref_mem[idx], wd, be);
         else if (k == K_FETCH) exp_inst = ref_mem[idx];
         else exp_data = ref_mem[idx];
         n_tests++; if (tmo !== 1'b0 || lat != ((k == K_STORE) ? WR_LAT : RD_LAT) || as !== AW'(idx)) begin n_fail++;
            $display("FAIL rand_timing[%0d]: got lat %0d addr %h expected lat %0d addr %h", n, lat, as,
                     (k == K_STORE) ? WR_LAT : RD_LAT, idx); end
         n_tests++; if (cpu.inst_rdata !== exp_inst || cpu.data_rdata !== exp_data) begin n_fail++;
            $display("FAIL rand_rdata[%0d]: got %h/%h expected %h/%h", n, cpu.inst_rdata, cpu.data_rdata, exp_inst, exp_data); end
         n_tests++; if (dev_mem[idx] !== ref_mem[idx]) begin n_fail++;
            $display("FAIL rand_memory[%0d]: got %h expected %h", n, dev_mem[idx], ref_mem[idx]); end
      end
   endtask

   task automatic test_contention();
      int grant, t_d, t_i, ii, di;
      ii = 8'h60; di = 8'h61;
      cpu.inst_req = 1'b1; cpu.inst_addr = {22'h0, 8'(ii), 2'b00};
      cpu.data_read = 1'b1; cpu.data_addr = {22'h0, 8'(di), 2'b00};
      grant = cyc + 1; t_d = -1; t_i = -1;
      for (int i = 0; i < 24 && t_i < 0; i++) begin
         @(negedge clk);
         if (cpu.data_ready) begin t_d = cyc + 1; cpu.data_read = 1'b0; end
         if (cpu.inst_ready) begin t_i = cyc + 1; cpu.inst_req = 1'b0; end
      end
      cpu.inst_req = 1'b0; cpu.data_read = 1'b0;
      exp_inst = ref_mem[ii]; exp_data = ref_mem[di];
      n_tests++; if (t_d - grant != RD_LAT) begin n_fail++;
         $display("FAIL contention_data_first: got %0d expected %0d", t_d - grant, RD_LAT); end
      // The fetch follows one full read period later: DONE, IDLE, then its own read.
      n_tests++; if (t_i < 0 || t_i - t_d != RD_PER) begin n_fail++;
         $display("FAIL contention_fetch_gap: got %0d expected %0d", t_i - t_d, RD_PER); end
      n_tests++; if (cpu.inst_rdata !== exp_inst || cpu.data_rdata !== exp_data) begin n_fail++;
         $display("FAIL contention_rdata: got %h/%h expected %h/%h", cpu.inst_rdata, cpu.data_rdata, exp_inst, exp_data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      int pulses; int lat, oe, we, su, ip, dp; logic [3:0] bs; logic [AW-1:0] as; logic tmo;
      bit seen;
      cpu.data_write = 1'b1; cpu.data_addr = 32'h0000_0200; cpu.data_wdata = $urandom; cpu.data_be = 4'hF;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (!sram_we_n) seen = 1'b1;
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL rstmid_pulse: got no we_n pulse expected one"); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1) begin n_fail++;
         $display("FAIL rstmid_async: got we_n %b ce_n %b expected 1 1", sram_we_n, sram_ce_n); end
      cpu.data_write = 1'b0;
      pulses = 0;
      for (int i = 0; i < 2; i++) begin @(negedge clk); pulses += int'(cpu.data_ready) + int'(cpu.inst_ready); end
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin @(negedge clk); pulses += int'(cpu.data_ready) + int'(cpu.inst_ready); end
      n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL rstmid_no_ready: got %0d expected 0", pulses); end
      exp_inst = '0; exp_data = '0;
      ref_mem[8'h80] = dev_mem[8'h80];
      n_tests++; if (cpu.inst_rdata !== exp_inst || cpu.data_rdata !== exp_data) begin n_fail++;
         $display("FAIL rstmid_rdata: got %h/%h expected 0/0", cpu.inst_rdata, cpu.data_rdata); end
      run_access(K_FETCH, 32'h0000_0020, 32'h0, 4'h0, lat, oe, we, su, bs, as, ip, dp, tmo);
      exp_inst = ref_mem[8];
      n_tests++; if (tmo !== 1'b0 || lat != RD_LAT || cpu.inst_rdata !== exp_inst) begin n_fail++;
         $display("FAIL rstmid_idle_after: got lat %0d rdata %h expected %0d %h", lat, cpu.inst_rdata, RD_LAT, exp_inst); end
   endtask

   task automatic test_held();
      int grant, pulses, extra; int t [0:2];
      cpu.inst_req = 1'b1; cpu.inst_addr = 32'h0000_0034;
      exp_inst = ref_mem[8'h0D];
      grant = cyc + 1; pulses = 0; extra = 0;
      t[0] = 0; t[1] = 0; t[2] = 0;
      for (int i = 0; i < 30 && pulses < 3; i++) begin
         @(negedge clk);
         if (cpu.data_ready) extra++;
         if (cpu.inst_ready) begin
            t[pulses] = cyc + 1;
            pulses++;
            if (pulses == 3) cpu.inst_req = 1'b0;
         end
      end
      cpu.inst_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         extra += int'(cpu.inst_ready) + int'(cpu.data_ready);
      end
      n_tests++; if (pulses != 3 || extra != 0) begin n_fail++;
         $display("FAIL held_pulses: got %0d extra %0d expected 3 extra 0", pulses, extra); end
      n_tests++; if (t[0] - grant != RD_LAT || t[1] - t[0] != RD_PER || t[2] - t[1] != RD_PER) begin n_fail++;
         $display("FAIL held_spacing: got %0d %0d %0d expected %0d %0d %0d", t[0] - grant, t[1] - t[0], t[2] - t[1],
                  RD_LAT, RD_PER, RD_PER); end
      n_tests++; if (cpu.inst_rdata !== exp_inst) begin n_fail++;
         $display("FAIL held_rdata: got %h expected %h", cpu.inst_rdata, exp_inst); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      ref_mem[4] = 32'hDEAD_BEEF;
      cpu.inst_req = 1'b0; cpu.inst_addr = '0;
      cpu.data_read = 1'b0; cpu.data_write = 1'b0;
      cpu.data_addr = '0; cpu.data_wdata = '0; cpu.data_be = '0;
      test_reset();
      test_fetch();
      test_store(K_STORE);
      test_random();
      test_contention();
      test_store(K_BOTH);
      test_reset_mid_write();
      test_held();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
